// File: rtl/mem_stage_if.sv
// Bundle of the MEM-stage signals: execute-stage inputs, data-cache handshake,
// forwarding source and writeback request. The slave modport is the MEM stage itself.
interface mem_stage_if #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
);
  logic              memen;
  logic              flush;
  logic [WORD_W-1:0] ex_nPC;
  logic [WORD_W-1:0] ex_ALUOut;
  logic [WORD_W-1:0] ex_dmemstore;
  logic              ex_dREN;
  logic              ex_dWEN;
  logic              ex_regWr;
  logic              ex_lui;
  logic              ex_halt;
  logic [1:0]        ex_regSel;
  logic [REG_W-1:0]  ex_regDst;
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;
  logic              mem_stall;
  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_reg;
  logic [WORD_W-1:0] fwd_dat;
  logic              wb_regWr;
  logic [REG_W-1:0]  wb_regDst;
  logic [WORD_W-1:0] wb_wdat;
  logic              halt;

  modport slave (
    input  memen, flush, ex_nPC, ex_ALUOut, ex_dmemstore, ex_dREN, ex_dWEN,
           ex_regWr, ex_lui, ex_halt, ex_regSel, ex_regDst, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, fwd_valid,
           fwd_reg, fwd_dat, wb_regWr, wb_regDst, wb_wdat, halt
  );

  modport master (
    output memen, flush, ex_nPC, ex_ALUOut, ex_dmemstore, ex_dREN, ex_dWEN,
           ex_regWr, ex_lui, ex_halt, ex_regSel, ex_regDst, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, fwd_valid,
           fwd_reg, fwd_dat, wb_regWr, wb_regDst, wb_wdat, halt
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM entry with data-cache handshake FSM, write-value
// select, MEM-stage forwarding source and the MEM/WB register with sticky halt.
module mem_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input logic         CLK,
  input logic         RST,
  mem_stage_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ALU, ST_ACCESS} state_t;

  state_t            r_state;
  logic              r_valid;
  logic [WORD_W-1:0] r_nPC;
  logic [WORD_W-1:0] r_ALUOut;
  logic [WORD_W-1:0] r_store;
  logic              r_dREN;
  logic              r_dWEN;
  logic              r_regWr;
  logic              r_lui;
  logic              r_halt_e;
  logic [1:0]        r_regSel;
  logic [REG_W-1:0]  r_regDst;

  logic              r_wb_regWr;
  logic [REG_W-1:0]  r_wb_regDst;
  logic [WORD_W-1:0] r_wb_wdat;
  logic              r_halt;

  logic              w_req;
  logic              w_stall;
  logic              w_handoff;
  logic              w_halt_set;

  function automatic logic [WORD_W-1:0] f_wval(
    input logic              lui,
    input logic [1:0]        sel,
    input logic [WORD_W-1:0] alu,
    input logic [WORD_W-1:0] ld,
    input logic [WORD_W-1:0] npc,
    input logic              use_ld
  );
    logic [WORD_W-1:0] v;
    if (lui) begin
      v = {alu[15:0], {(WORD_W-16){1'b0}}};
    end else begin
      case (sel)
        2'd1:    v = use_ld ? ld : alu;
        2'd2:    v = npc;
        default: v = alu;
      endcase
    end
    return v;
  endfunction

  assign w_req      = (r_state == ST_ACCESS);
  assign w_stall    = w_req & ~bus.dhit;
  assign w_handoff  = (r_state == ST_ALU) | (w_req & bus.dhit);
  assign w_halt_set = w_handoff & r_halt_e;

  // EX/MEM boundary: entry load, hold, bubble and handshake state
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_nPC    <= '0;
      r_ALUOut <= '0;
      r_store  <= '0;
      r_dREN   <= 1'b0;
      r_dWEN   <= 1'b0;
      r_regWr  <= 1'b0;
      r_lui    <= 1'b0;
      r_halt_e <= 1'b0;
      r_regSel <= 2'd0;
      r_regDst <= '0;
      r_halt   <= 1'b0;
    end else begin
      if (w_halt_set) r_halt <= 1'b1;
      // A halted core accepts nothing more; the halting edge itself loads nothing.
      if (r_halt || w_halt_set) begin
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
      end else if (bus.flush && !w_req) begin
        r_state  <= ST_IDLE;
        r_valid  <= 1'b0;
        r_dREN   <= 1'b0;
        r_dWEN   <= 1'b0;
        r_regWr  <= 1'b0;
        r_lui    <= 1'b0;
        r_halt_e <= 1'b0;
        r_regSel <= 2'd0;
      end else if (bus.memen && !w_stall) begin
        r_state  <= (bus.ex_dREN || bus.ex_dWEN) ? ST_ACCESS : ST_ALU;
        r_valid  <= 1'b1;
        r_nPC    <= bus.ex_nPC;
        r_ALUOut <= bus.ex_ALUOut;
        r_store  <= bus.ex_dmemstore;
        r_dREN   <= bus.ex_dREN;
        r_dWEN   <= bus.ex_dWEN;
        r_regWr  <= bus.ex_regWr;
        r_lui    <= bus.ex_lui;
        r_halt_e <= bus.ex_halt;
        r_regSel <= bus.ex_regSel;
        r_regDst <= bus.ex_regDst;
      end else if (w_handoff) begin
        r_state <= ST_IDLE;
      end
    end
  end

  // MEM/WB boundary: one write pulse per handed-off instruction
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wb_regWr  <= 1'b0;
      r_wb_regDst <= '0;
      r_wb_wdat   <= '0;
    end else if (w_handoff) begin
      r_wb_regWr  <= r_regWr;
      r_wb_regDst <= r_regDst;
      r_wb_wdat   <= f_wval(r_lui, r_regSel, r_ALUOut, bus.dmemload, r_nPC, 1'b1);
    end else begin
      r_wb_regWr  <= 1'b0;
    end
  end

  assign bus.dmemREN   = w_req & r_dREN;
  assign bus.dmemWEN   = w_req & r_dWEN;
  assign bus.dmemaddr  = r_ALUOut;
  assign bus.dmemstore = r_store;
  assign bus.mem_stall = w_stall;

  // Loads are not forwarded from here; their data only exists at the dhit edge.
  assign bus.fwd_valid = r_valid & r_regWr & ~r_dREN & (r_state != ST_IDLE);
  assign bus.fwd_reg   = r_regDst;
  assign bus.fwd_dat   = f_wval(r_lui, r_regSel, r_ALUOut, '0, r_nPC, 1'b0);

  assign bus.wb_regWr  = r_wb_regWr;
  assign bus.wb_regDst = r_wb_regDst;
  assign bus.wb_wdat   = r_wb_wdat;
  assign bus.halt      = r_halt;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic against an
// instruction-level occupancy model of the memory stage.
module tb_mem_stage;

  typedef struct {
    logic [31:0] npc;
    logic [31:0] alu;
    logic [31:0] st;
    logic        dren;
    logic        dwen;
    logic        regwr;
    logic        lui;
    logic        halt;
    logic [1:0]  sel;
    logic [4:0]  dst;
  } ins_t;

  logic CLK;
  logic RST;
  int   n_tests;
  int   n_fail;

  mem_stage_if #(.WORD_W(32), .REG_W(5)) bus ();

  mem_stage #(.WORD_W(32), .REG_W(5)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference state: the instruction occupying MEM (if any) and the WB register.
  bit          m_have;
  ins_t        m_e;
  bit          m_halt;
  logic        m_wr;
  logic [4:0]  m_dst;
  logic [31:0] m_wdat;

  ins_t        cur;
  logic        memen, flush, dhit;
  logic [31:0] dmemload;
  logic        s_stall;

  always @(posedge CLK) begin
    if (!RST) assert (!(bus.flush && (bus.dmemREN || bus.dmemWEN)))
      else $error("flush raised while a cache request is outstanding");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] wval(input ins_t e, input logic [31:0] ld, input bit use_ld);
    if (e.lui) return {e.alu[15:0], 16'h0000};
    if (e.sel == 2'd2) return e.npc;
    if (e.sel == 2'd1 && use_ld) return ld;
    return e.alu;
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i.npc = 0; i.alu = 0; i.st = 0; i.dren = 0; i.dwen = 0;
    i.regwr = 0; i.lui = 0; i.halt = 0; i.sel = 0; i.dst = 0;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    int   k;
    i.npc = $urandom; i.alu = $urandom; i.st = $urandom;
    k = $urandom_range(0, 2);
    i.dren  = (k == 1);
    i.dwen  = (k == 2);
    i.regwr = 1'($urandom_range(0, 1));
    i.lui   = ($urandom_range(0, 7) == 0);
    i.halt  = 1'b0;
    i.sel   = 2'($urandom_range(0, 3));
    i.dst   = 5'($urandom);
    return i;
  endfunction

  function automatic bit model_req();
    return m_have && (m_e.dren || m_e.dwen);
  endfunction

  task automatic apply();
    bus.ex_nPC = cur.npc; bus.ex_ALUOut = cur.alu; bus.ex_dmemstore = cur.st;
    bus.ex_dREN = cur.dren; bus.ex_dWEN = cur.dwen; bus.ex_regWr = cur.regwr;
    bus.ex_lui = cur.lui; bus.ex_halt = cur.halt; bus.ex_regSel = cur.sel;
    bus.ex_regDst = cur.dst;
    bus.memen = memen; bus.flush = flush; bus.dhit = dhit; bus.dmemload = dmemload;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model, check WB.
  task automatic step();
    bit req, stall, done, fv;
    apply();
    @(negedge CLK);
    req   = model_req();
    stall = req && !dhit;
    fv    = m_have && m_e.regwr && !m_e.dren;
    s_stall = bus.mem_stall;
    check("dmemREN", 64'(bus.dmemREN), 64'(req && m_e.dren));
    check("dmemWEN", 64'(bus.dmemWEN), 64'(req && m_e.dwen));
    check("mem_stall", 64'(bus.mem_stall), 64'(stall));
    check("fwd_valid", 64'(bus.fwd_valid), 64'(fv));
    if (fv) begin
      check("fwd_reg", 64'(bus.fwd_reg), 64'(m_e.dst));
      check("fwd_dat", 64'(bus.fwd_dat), 64'(wval(m_e, 32'h0, 1'b0)));
    end
    if (req) begin
      check("dmemaddr", 64'(bus.dmemaddr), 64'(m_e.alu));
      check("dmemstore", 64'(bus.dmemstore), 64'(m_e.st));
    end
    done = m_have && (!req || dhit);
    if (done) begin
      m_wr = m_e.regwr; m_dst = m_e.dst; m_wdat = wval(m_e, dmemload, 1'b1);
      if (m_e.halt) m_halt = 1'b1;
    end else begin
      m_wr = 1'b0;
    end
    if (m_halt) m_have = 0;
    else if (flush && !req) m_have = 0;
    else if (memen && !stall) begin m_have = 1; m_e = cur; end
    else if (done) m_have = 0;
    @(posedge CLK); #1;
    check("wb_regWr", 64'(bus.wb_regWr), 64'(m_wr));
    check("wb_regDst", 64'(bus.wb_regDst), 64'(m_dst));
    check("wb_wdat", 64'(bus.wb_wdat), 64'(m_wdat));
    check("halt", 64'(bus.halt), 64'(m_halt));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cur = rnd_ins(); cur.halt = 1'b1; cur.dren = 1'b1;
    memen = 1'b1; flush = 1'($urandom_range(0, 1)); dhit = 1'b1; dmemload = $urandom;
    apply();
    repeat (2) @(posedge CLK);
    #1;
    check("rst dmemREN", 64'(bus.dmemREN), 64'd0);
    check("rst dmemWEN", 64'(bus.dmemWEN), 64'd0);
    check("rst dmemaddr", 64'(bus.dmemaddr), 64'd0);
    check("rst dmemstore", 64'(bus.dmemstore), 64'd0);
    check("rst mem_stall", 64'(bus.mem_stall), 64'd0);
    check("rst fwd_valid", 64'(bus.fwd_valid), 64'd0);
    check("rst wb_regWr", 64'(bus.wb_regWr), 64'd0);
    check("rst wb_regDst", 64'(bus.wb_regDst), 64'd0);
    check("rst wb_wdat", 64'(bus.wb_wdat), 64'd0);
    check("rst halt", 64'(bus.halt), 64'd0);
    m_have = 0; m_e = nop(); m_halt = 0; m_wr = 0; m_dst = 0; m_wdat = 0;
    RST = 1'b0;
    cur = nop(); memen = 0; flush = 0; dhit = 0; dmemload = 0;
    apply();
  endtask

  initial begin
    int stalls;
    n_tests = 0; n_fail = 0;
    do_reset();

    // ALU op
    cur = nop(); cur.alu = 32'h1234; cur.dst = 5'd8; cur.regwr = 1; memen = 1;
    step();
    cur = nop(); memen = 0;
    step();
    check("alu wb_wdat", 64'(bus.wb_wdat), 64'h1234);
    check("alu wb_regWr", 64'(bus.wb_regWr), 64'd1);
    step();

    // load with a 3-cycle miss
    cur = nop(); cur.alu = 32'h40; cur.dst = 5'd3; cur.regwr = 1; cur.sel = 2'd1;
    cur.dren = 1; memen = 1;
    step();
    cur = nop(); memen = 0; dmemload = 32'hDEADBEEF; stalls = 0;
    for (int i = 0; i < 3; i++) begin
      dhit = (i == 2);
      step();
      stalls += int'(s_stall);
    end
    dhit = 0;
    check("load stall cycles", 64'(stalls), 64'd2);
    check("load wb_wdat", 64'(bus.wb_wdat), 64'hDEADBEEF);
    step();

    // store with same-cycle hit, then an ALU op
    cur = nop(); cur.alu = 32'h80; cur.st = 32'hCAFE; cur.dwen = 1; memen = 1;
    step();
    cur = nop(); cur.alu = 32'h55; cur.dst = 5'd9; cur.regwr = 1; dhit = 1;
    step();
    check("store no stall", 64'(s_stall), 64'd0);
    cur = nop(); memen = 0; dhit = 0;
    step();
    check("alu after store", 64'(bus.wb_wdat), 64'h55);

    // lui and jal
    cur = nop(); cur.alu = 32'h0000ABCD; cur.lui = 1; cur.dst = 5'd1; cur.regwr = 1; memen = 1;
    step();
    cur = nop(); cur.npc = 32'h104; cur.sel = 2'd2; cur.dst = 5'd31; cur.regwr = 1;
    step();
    check("lui wb_wdat", 64'(bus.wb_wdat), 64'hABCD0000);
    memen = 0;
    step();
    check("jal wb_wdat", 64'(bus.wb_wdat), 64'h104);

    // flush with a valid instruction
    cur = nop(); cur.alu = 32'h77; cur.dst = 5'd4; cur.regwr = 1; memen = 1; flush = 1;
    step();
    flush = 0; memen = 0;
    step();
    check("flush wb_regWr", 64'(bus.wb_regWr), 64'd0);

    // reset abandons an outstanding request
    cur = nop(); cur.alu = 32'h90; cur.dren = 1; memen = 1;
    step();
    do_reset();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      cur = rnd_ins();
      memen = ($urandom_range(0, 3) != 0);
      dhit  = ($urandom_range(0, 2) == 0);
      dmemload = $urandom;
      flush = !model_req() && ($urandom_range(0, 9) == 0);
      step();
    end

    // halt, further stimulus, then reset
    cur = nop(); cur.halt = 1; memen = 1; flush = 0; dhit = 0;
    step();
    step();
    step();
    check("halt set", 64'(bus.halt), 64'd1);
    for (int n = 0; n < 30; n++) begin
      cur = rnd_ins();
      memen = 1'($urandom_range(0, 1));
      dhit  = 1'($urandom_range(0, 1));
      dmemload = $urandom;
      flush = 1'b0;
      step();
    end
    check("halt sticky", 64'(bus.halt), 64'd1);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
